vector_bank_ctrl: RTL and testbench

// - Double-buffer scheduler for the vector display list. Sits between memory_manage (writer) and the line drawer (reader).
// - Writer fills the back RAM bank while the reader streams the front bank. Banks swap at the frame boundary only.
// - Paces the writer with a frame_done pulse. Repeats the front frame when no new frame is ready.

---
 rtl/vector_pkg.sv | 27 ++
 rtl/vector_fetch.sv | 116 +++++++++++
 rtl/vector_bank_ctrl.sv | 116 +++++++++++
 tb/tb_vector_bank_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and helpers for the vector display-list double buffer.
// A vector word is {x, y, line, pos}; line & pos together mark the frame terminator.
package vector_pkg;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       line;
    logic       pos;
  } vector_t;

  localparam vector_t TERM_WORD = '{x: 8'd0, y: 8'd0, line: 1'b1, pos: 1'b1};

  typedef enum logic [2:0] {
    R_IDLE,
    R_ADDR,
    R_WAIT,
    R_HOLD,
    R_END
  } rd_state_e;

  // Only the line/pos flags identify the terminator; x and y are don't-care.
  function automatic logic is_term(input vector_t v);
    return (v & TERM_WORD) == TERM_WORD;
  endfunction

endpackage

// File: rtl/vector_fetch.sv
// Front-bank reader: owns the read pointer, the fetch FSM and the RAM latency wait.
// It decides when a swap or a frame repeat happens; the top applies the bank-side effects.
//
// state  | meaning
// R_IDLE | no valid front frame yet; swap in as soon as the back bank is full
// R_ADDR | read address driven from rd_ptr
// R_WAIT | RAM latency; last cycle captures the front-bank word
// R_HOLD | vector presented, held until the reader accepts it
// R_END  | frame finished; swap or repeat, rewind pointer
module vector_fetch
  import vector_pkg::*;
#(
  parameter int ADR_WIDTH  = 16,
  parameter int DATAWIDTH  = 18,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 front_valid_i,
  input  logic                 back_full_i,
  input  logic                 build_done_i,
  input  logic                 front_bank_i,
  input  logic [DATAWIDTH-1:0] rdata0_i,
  input  logic [DATAWIDTH-1:0] rdata1_i,
  input  logic                 vec_ready_i,
  output logic                 swap_o,
  output logic                 repeat_o,
  output logic [ADR_WIDTH-1:0] radr_o,
  output logic                 vec_valid_o,
  output logic [DATAWIDTH-1:0] vec_data_o,
  output logic                 vec_last_o
);

  localparam logic [1:0] WAIT_LOAD = 2'(RD_LATENCY - 1);

  rd_state_e            state_q;
  logic [ADR_WIDTH-1:0] rd_ptr_q;
  logic [1:0]           wait_q;
  logic                 vec_valid_q;
  logic [DATAWIDTH-1:0] vec_data_q;
  logic                 vec_last_q;

  logic [DATAWIDTH-1:0] front_rdata;
  vector_t              front_vec;
  logic                 ptr_at_max;
  logic                 end_swap;

  assign front_rdata = front_bank_i ? rdata1_i : rdata0_i;
  assign front_vec   = front_rdata[$bits(vector_t)-1:0];
  assign ptr_at_max  = (rd_ptr_q == {ADR_WIDTH{1'b1}});

  // A build_done arriving in the R_END cycle counts as a full back bank.
  assign end_swap = back_full_i | build_done_i;
  assign swap_o   = ((state_q == R_IDLE) & ~front_valid_i & back_full_i) |
                    ((state_q == R_END) & end_swap);
  assign repeat_o = (state_q == R_END) & ~end_swap;

  assign radr_o      = rd_ptr_q;
  assign vec_valid_o = vec_valid_q;
  assign vec_data_o  = vec_data_q;
  assign vec_last_o  = vec_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= R_IDLE;
      rd_ptr_q    <= '0;
      wait_q      <= '0;
      vec_valid_q <= 1'b0;
      vec_data_q  <= '0;
      vec_last_q  <= 1'b0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (front_valid_i || back_full_i) begin
            rd_ptr_q <= '0;
            state_q  <= R_ADDR;
          end
        end
        R_ADDR: begin
          wait_q  <= WAIT_LOAD;
          state_q <= R_WAIT;
        end
        R_WAIT: begin
          if (wait_q == 2'd0) begin
            vec_data_q  <= front_rdata;
            // The last address of the bank always closes the frame so the pointer cannot wrap.
            vec_last_q  <= is_term(front_vec) | ptr_at_max;
            vec_valid_q <= 1'b1;
            state_q     <= R_HOLD;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        R_HOLD: begin
          if (vec_ready_i) begin
            vec_valid_q <= 1'b0;
            if (vec_last_q) begin
              state_q <= R_END;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
              state_q  <= R_ADDR;
            end
          end
        end
        R_END: begin
          rd_ptr_q <= '0;
          state_q  <= R_ADDR;
        end
        default: begin
          state_q <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/vector_bank_ctrl.sv
// Double-buffer scheduler between the display-list writer and the line drawer.
// Holds bank ownership, steers writes to the back bank and paces the writer with frame_done.
module vector_bank_ctrl
  import vector_pkg::*;
#(
  parameter int ADR_WIDTH  = 16,
  parameter int DATAWIDTH  = 18,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADR_WIDTH-1:0] wr_adr,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 build_done,
  output logic                 frame_done,
  output logic [1:0]           ram_we,
  output logic [ADR_WIDTH-1:0] ram_wadr,
  output logic [DATAWIDTH-1:0] ram_wdata,
  output logic [ADR_WIDTH-1:0] ram_radr,
  input  logic [DATAWIDTH-1:0] ram_rdata0,
  input  logic [DATAWIDTH-1:0] ram_rdata1,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  output logic [DATAWIDTH-1:0] vec_data,
  output logic                 vec_last,
  output logic                 front_bank,
  output logic                 err_overrun,
  output logic [7:0]           repeat_cnt
);

  logic       front_bank_q;
  logic       back_full_q;
  logic       back_full_d;
  logic       front_valid_q;
  logic       frame_done_q;
  logic       err_overrun_q;
  logic [7:0] repeat_cnt_q;
  logic [7:0] repeat_cnt_d;

  logic       swap;
  logic       rpt;
  logic       wr_ok;

  vector_fetch #(
    .ADR_WIDTH  (ADR_WIDTH),
    .DATAWIDTH  (DATAWIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_fetch (
    .clk           (clk),
    .rst           (rst),
    .front_valid_i (front_valid_q),
    .back_full_i   (back_full_q),
    .build_done_i  (build_done),
    .front_bank_i  (front_bank_q),
    .rdata0_i      (ram_rdata0),
    .rdata1_i      (ram_rdata1),
    .vec_ready_i   (vec_ready),
    .swap_o        (swap),
    .repeat_o      (rpt),
    .radr_o        (ram_radr),
    .vec_valid_o   (vec_valid),
    .vec_data_o    (vec_data),
    .vec_last_o    (vec_last)
  );

  // back_full only takes effect from the cycle after build_done, so a word written alongside it lands.
  assign wr_ok     = wr_en & ~back_full_q;
  assign ram_we    = front_bank_q ? {1'b0, wr_ok} : {wr_ok, 1'b0};
  assign ram_wadr  = wr_adr;
  assign ram_wdata = wr_data;

  always_comb begin
    back_full_d  = back_full_q;
    repeat_cnt_d = repeat_cnt_q;
    if (swap) begin
      back_full_d  = 1'b0;
      repeat_cnt_d = 8'd0;
    end else begin
      if (build_done) begin
        back_full_d = 1'b1;
      end
      if (rpt && (repeat_cnt_q != 8'hFF)) begin
        repeat_cnt_d = repeat_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_bank_q  <= 1'b0;
      back_full_q   <= 1'b0;
      front_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      repeat_cnt_q  <= 8'd0;
    end else begin
      back_full_q  <= back_full_d;
      repeat_cnt_q <= repeat_cnt_d;
      frame_done_q <= swap;
      if (swap) begin
        front_bank_q  <= ~front_bank_q;
        front_valid_q <= 1'b1;
      end
      if (wr_en && back_full_q) begin
        err_overrun_q <= 1'b1;
      end
    end
  end

  assign frame_done  = frame_done_q;
  assign front_bank  = front_bank_q;
  assign err_overrun = err_overrun_q;
  assign repeat_cnt  = repeat_cnt_q;

endmodule

// File: tb/tb_vector_bank_ctrl.sv
// Bench for vector_bank_ctrl: two-bank RAM model, random frames, scoreboard of bank contents.
module tb_vector_bank_ctrl;
  import vector_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 18;
  localparam int LAT   = 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_adr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          build_done = 1'b0;
  logic          vec_ready = 1'b0;
  logic          frame_done;
  logic [1:0]    ram_we;
  logic [AW-1:0] ram_wadr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_radr;
  logic [DW-1:0] ram_rdata0 = '0;
  logic [DW-1:0] ram_rdata1 = '0;
  logic          vec_valid;
  logic [DW-1:0] vec_data;
  logic          vec_last;
  logic          front_bank;
  logic          err_overrun;
  logic [7:0]    repeat_cnt;

  always #5 clk = ~clk;

  vector_bank_ctrl #(.ADR_WIDTH(AW), .DATAWIDTH(DW), .RD_LATENCY(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_adr      (wr_adr),
    .wr_data     (wr_data),
    .build_done  (build_done),
    .frame_done  (frame_done),
    .ram_we      (ram_we),
    .ram_wadr    (ram_wadr),
    .ram_wdata   (ram_wdata),
    .ram_radr    (ram_radr),
    .ram_rdata0  (ram_rdata0),
    .ram_rdata1  (ram_rdata1),
    .vec_valid   (vec_valid),
    .vec_ready   (vec_ready),
    .vec_data    (vec_data),
    .vec_last    (vec_last),
    .front_bank  (front_bank),
    .err_overrun (err_overrun),
    .repeat_cnt  (repeat_cnt)
  );

  // single-cycle-latency synchronous RAMs
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (ram_we[0]) mem0[ram_wadr] <= ram_wdata;
    if (ram_we[1]) mem1[ram_wadr] <= ram_wdata;
    ram_rdata0 <= mem0[ram_radr];
    ram_rdata1 <= mem1[ram_radr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: what each bank should hold and the bank bookkeeping
  logic [DW-1:0] m_bank [2][DEPTH];
  bit            m_front = 1'b0;
  bit            m_full  = 1'b0;
  bit            m_err   = 1'b0;
  int            m_rep   = 0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] w;
    w    = DW'($urandom);
    w[0] = w[0] & ~w[1];
    return w;
  endfunction

  task automatic wr(input int adr, input logic [DW-1:0] d, input bit bd);
    wr_en      = 1'b1;
    wr_adr     = AW'(adr);
    wr_data    = d;
    build_done = bd;
    #1;
    chk("ram_we", 32'(ram_we), m_full ? 32'd0 : (m_front ? 32'd1 : 32'd2));
    chk("ram_wadr", 32'(ram_wadr), 32'(adr));
    chk("ram_wdata", 32'(ram_wdata), 32'(d));
    if (m_full) m_err = 1'b1;
    else m_bank[!m_front][adr] = d;
    tick();
    wr_en      = 1'b0;
    build_done = 1'b0;
    if (bd) m_full = 1'b1;
    chk("err_overrun", 32'(err_overrun), 32'(m_err));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!vec_valid && n < 50) begin
      tick();
      n++;
    end
    chk("vec_valid", 32'(vec_valid), 32'd1);
  endtask

  task automatic read_frame(input bit end_build, input int max_stall);
    int            idx;
    int            t_acc;
    bit            last_exp;
    bit            swap_exp;
    logic [DW-1:0] d_exp;
    logic [DW-1:0] held;
    idx      = 0;
    t_acc    = 0;
    last_exp = 1'b0;
    do begin
      wait_valid();
      if (idx > 0) chk("accept_to_valid", 32'(cyc - t_acc), 32'(2 + LAT));
      d_exp    = m_bank[m_front][idx];
      last_exp = (d_exp[1:0] == 2'b11) || (idx == DEPTH - 1);
      chk("vec_data", 32'(vec_data), 32'(d_exp));
      chk("vec_last", 32'(vec_last), 32'(last_exp));
      held = vec_data;
      repeat ($urandom_range(max_stall, 0)) begin
        tick();
        chk("hold_data", 32'(vec_data), 32'(held));
      end
      vec_ready = 1'b1;
      t_acc     = cyc;
      tick();
      vec_ready = 1'b0;
      idx++;
    end while (!last_exp && idx < DEPTH);
    if (end_build) build_done = 1'b1;
    swap_exp = m_full || end_build;
    tick();
    build_done = 1'b0;
    if (swap_exp) begin
      m_front = !m_front;
      m_full  = 1'b0;
      m_rep   = 0;
    end else if (m_rep < 255) begin
      m_rep++;
    end
    chk("frame_done", 32'(frame_done), 32'(swap_exp));
    chk("front_bank", 32'(front_bank), 32'(m_front));
    chk("repeat_cnt", 32'(repeat_cnt), 32'(m_rep));
    tick();
    chk("frame_done_once", 32'(frame_done), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vec_valid"}, 32'(vec_valid), 32'd0);
    chk({tag, "_vec_data"}, 32'(vec_data), 32'd0);
    chk({tag, "_vec_last"}, 32'(vec_last), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_err"}, 32'(err_overrun), 32'd0);
    chk({tag, "_repeat"}, 32'(repeat_cnt), 32'd0);
    chk({tag, "_front"}, 32'(front_bank), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] held;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_all_zero("reset");
    repeat (20) begin
      tick();
      chk("idle_valid", 32'(vec_valid), 32'd0);
    end

    // first frame into bank 1, swapped in from idle
    for (int i = 0; i < 3; i++) wr(i, rnd_vec(), 1'b0);
    wr(3, TERM_WORD, 1'b0);
    build_done = 1'b1;
    tick();
    build_done = 1'b0;
    m_full = 1'b1;
    tick();
    m_front = 1'b1;
    m_full  = 1'b0;
    chk("init_frame_done", 32'(frame_done), 32'd1);
    chk("init_front_bank", 32'(front_bank), 32'd1);
    tick();
    chk("init_frame_done_once", 32'(frame_done), 32'd0);

    // stream and repeat until repeat_cnt saturates
    for (int f = 0; f < 3; f++) read_frame(1'b0, 3);
    for (int f = 0; f < 254; f++) read_frame(1'b0, 0);
    chk("repeat_sat", 32'(repeat_cnt), 32'd255);

    // new frame into bank 0, build_done lands in the end-of-frame cycle
    for (int i = 0; i < 5; i++) wr(i, rnd_vec(), 1'b0);
    wr(5, TERM_WORD, 1'b0);
    read_frame(1'b1, 2);

    // word with build_done is kept, the following one is dropped
    wr(0, rnd_vec(), 1'b0);
    wr(1, rnd_vec(), 1'b0);
    wr(2, TERM_WORD, 1'b1);
    wr(3, rnd_vec(), 1'b0);
    read_frame(1'b0, 2);
    read_frame(1'b0, 2);
    chk("err_sticky", 32'(err_overrun), 32'd1);

    // unterminated full bank: last forced at the top address
    for (int i = 0; i < DEPTH; i++) wr(i, rnd_vec(), i == DEPTH - 1);
    read_frame(1'b0, 1);
    read_frame(1'b0, 1);

    // long stall, then reset mid-frame
    wait_valid();
    held = vec_data;
    repeat (10) begin
      tick();
      chk("stall_data", 32'(vec_data), 32'(held));
      chk("stall_valid", 32'(vec_valid), 32'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_front = 1'b0;
    m_full  = 1'b0;
    m_err   = 1'b0;
    m_rep   = 0;
    check_all_zero("midrst");
    repeat (10) begin
      tick();
      chk("post_rst_valid", 32'(vec_valid), 32'd0);
    end
    wr(0, rnd_vec(), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
